// File: rtl/programm_lader.sv
// Boot loader: reads the program length from SD word 0, then copies SD words 1..N
// into RAM words 0..N-1 while holding the CPU in reset.
module programm_lader #(
  parameter int ANFRAGEPAUSE = 32,
  parameter int MAXWORTE     = 32768
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Start,
  output logic [31:0] SDAdresse,
  output logic        SDLesen,
  input  logic [31:0] SDDaten,
  input  logic        SDBusy,
  output logic [31:0] RAMAdresse,
  output logic [31:0] RAMDaten,
  output logic        RAMSchreiben,
  input  logic        RAMGeschrieben,
  output logic        CPUReset,
  output logic        Fertig,
  output logic        Fehler,
  output logic [2:0]  Zustand
);

  typedef enum logic [2:0] {
    S_WARTEN    = 3'd0,
    S_PAUSE     = 3'd1,
    S_ANFRAGE   = 3'd2,
    S_AUF_BUSY  = 3'd3,
    S_AUF_DATEN = 3'd4,
    S_SCHREIBEN = 3'd5,
    S_FERTIG    = 3'd6,
    S_FEHLER    = 3'd7
  } zustand_t;

  localparam logic [7:0]  PAUSE_INIT = 8'(ANFRAGEPAUSE);
  localparam logic [31:0] MAX_LAENGE = 32'(MAXWORTE);

  zustand_t    zustand_q, zustand_d;
  logic [31:0] index_q, index_d;
  logic [31:0] laenge_q, laenge_d;
  logic [7:0]  pause_q, pause_d;
  logic [31:0] sd_adresse_q, sd_adresse_d;
  logic        sd_lesen_q, sd_lesen_d;
  logic [31:0] ram_adresse_q, ram_adresse_d;
  logic [31:0] ram_daten_q, ram_daten_d;
  logic        ram_schreiben_q, ram_schreiben_d;
  logic        cpu_reset_q, cpu_reset_d;
  logic        fertig_q, fertig_d;
  logic        fehler_q, fehler_d;

  always_comb begin
    zustand_d       = zustand_q;
    index_d         = index_q;
    laenge_d        = laenge_q;
    pause_d         = pause_q;
    sd_adresse_d    = sd_adresse_q;
    sd_lesen_d      = 1'b0;
    ram_adresse_d   = ram_adresse_q;
    ram_daten_d     = ram_daten_q;
    ram_schreiben_d = ram_schreiben_q;

    case (zustand_q)
      S_WARTEN: begin
        if (Start) begin
          index_d   = 32'd0;
          pause_d   = PAUSE_INIT;
          zustand_d = S_PAUSE;
        end
      end
      S_PAUSE: begin
        // SDLesen is registered, so it is high exactly while in ANFRAGE
        if (pause_q != 8'd0) begin
          pause_d = pause_q - 8'd1;
        end else if (!SDBusy) begin
          sd_lesen_d   = 1'b1;
          sd_adresse_d = index_q;
          zustand_d    = S_ANFRAGE;
        end
      end
      S_ANFRAGE: begin
        zustand_d = S_AUF_BUSY;
      end
      S_AUF_BUSY: begin
        if (SDBusy) zustand_d = S_AUF_DATEN;
      end
      S_AUF_DATEN: begin
        if (!SDBusy) begin
          if (index_q == 32'd0) begin
            laenge_d = SDDaten;
            if (SDDaten == 32'd0) begin
              zustand_d = S_FERTIG;
            end else if (SDDaten > MAX_LAENGE) begin
              zustand_d = S_FEHLER;
            end else begin
              index_d   = 32'd1;
              pause_d   = PAUSE_INIT;
              zustand_d = S_PAUSE;
            end
          end else begin
            ram_daten_d     = SDDaten;
            ram_adresse_d   = index_q - 32'd1;
            ram_schreiben_d = 1'b1;
            zustand_d       = S_SCHREIBEN;
          end
        end
      end
      S_SCHREIBEN: begin
        if (RAMGeschrieben) begin
          ram_schreiben_d = 1'b0;
          if (index_q == laenge_q) begin
            zustand_d = S_FERTIG;
          end else begin
            index_d   = index_q + 32'd1;
            pause_d   = PAUSE_INIT;
            zustand_d = S_PAUSE;
          end
        end
      end
      S_FERTIG: zustand_d = S_FERTIG;
      S_FEHLER: zustand_d = S_FEHLER;
      default:  zustand_d = S_WARTEN;
    endcase

    cpu_reset_d = (zustand_d != S_FERTIG);
    fertig_d    = (zustand_d == S_FERTIG);
    fehler_d    = (zustand_d == S_FEHLER);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      zustand_q       <= S_WARTEN;
      index_q         <= 32'd0;
      laenge_q        <= 32'd0;
      pause_q         <= 8'd0;
      sd_adresse_q    <= 32'd0;
      sd_lesen_q      <= 1'b0;
      ram_adresse_q   <= 32'd0;
      ram_daten_q     <= 32'd0;
      ram_schreiben_q <= 1'b0;
      cpu_reset_q     <= 1'b1;
      fertig_q        <= 1'b0;
      fehler_q        <= 1'b0;
    end else begin
      zustand_q       <= zustand_d;
      index_q         <= index_d;
      laenge_q        <= laenge_d;
      pause_q         <= pause_d;
      sd_adresse_q    <= sd_adresse_d;
      sd_lesen_q      <= sd_lesen_d;
      ram_adresse_q   <= ram_adresse_d;
      ram_daten_q     <= ram_daten_d;
      ram_schreiben_q <= ram_schreiben_d;
      cpu_reset_q     <= cpu_reset_d;
      fertig_q        <= fertig_d;
      fehler_q        <= fehler_d;
    end
  end

  assign SDAdresse    = sd_adresse_q;
  assign SDLesen      = sd_lesen_q;
  assign RAMAdresse   = ram_adresse_q;
  assign RAMDaten     = ram_daten_q;
  assign RAMSchreiben = ram_schreiben_q;
  assign CPUReset     = cpu_reset_q;
  assign Fertig       = fertig_q;
  assign Fehler       = fehler_q;
  assign Zustand      = zustand_q;

endmodule

// File: tb/tb_programm_lader.sv
// Directed bench for programm_lader with SD and RAM responder models and
// scoreboard queues of expected SD addresses and RAM writes.
module tb_programm_lader;
  localparam int P    = 4;
  localparam int MAXW = 32768;

  logic        clk = 1'b0;
  logic        Reset, Start, SDLesen, SDBusy, RAMSchreiben, RAMGeschrieben;
  logic        CPUReset, Fertig, Fehler;
  logic [31:0] SDAdresse, SDDaten, RAMAdresse, RAMDaten;
  logic [2:0]  Zustand;

  always #5 clk = ~clk;

  programm_lader #(.ANFRAGEPAUSE(P), .MAXWORTE(MAXW)) dut (
    .Clock(clk), .Reset(Reset), .Start(Start),
    .SDAdresse(SDAdresse), .SDLesen(SDLesen), .SDDaten(SDDaten), .SDBusy(SDBusy),
    .RAMAdresse(RAMAdresse), .RAMDaten(RAMDaten), .RAMSchreiben(RAMSchreiben),
    .RAMGeschrieben(RAMGeschrieben), .CPUReset(CPUReset), .Fertig(Fertig),
    .Fehler(Fehler), .Zustand(Zustand)
  );

  int passed = 0;
  int total  = 0;
  int cyc = 0, start_cyc = 0, last_lesen = -1;
  int lesen_count = 0, write_count = 0;
  int ram_delay = 0, busy_len = 1;
  logic prev_lesen = 1'b0;
  logic [31:0] sd_mem [0:7];
  logic [31:0] exp_sd_q[$];
  logic [63:0] exp_ram_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor: SDLesen pulse shape, spacing and scoreboarded SD addresses
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (SDLesen) begin
        lesen_count++;
        chk("lesen_puls", 32'(prev_lesen), 32'd0);
        chk("sd_erwartet", 32'(exp_sd_q.size() != 0), 32'd1);
        if (exp_sd_q.size() != 0) chk("sd_adresse", SDAdresse, exp_sd_q.pop_front());
        chk("ram_ruhig_bei_lesen", 32'(RAMSchreiben), 32'd0);
        if (last_lesen < 0) chk("erste_pause", 32'((cyc - start_cyc) >= P + 1), 32'd1);
        else                chk("lesen_abstand", 32'((cyc - last_lesen) >= P + 3), 32'd1);
        last_lesen = cyc;
      end
      prev_lesen = SDLesen;
    end
  end

  // SD card model: busy starts the cycle after the request
  initial begin
    logic [31:0] a;
    forever begin
      @(negedge clk);
      if (SDLesen) begin
        a = SDAdresse;
        @(negedge clk);
        SDBusy  = 1'b1;
        SDDaten = sd_mem[a[2:0]];
        repeat (busy_len) @(negedge clk);
        SDBusy = 1'b0;
      end
    end
  end

  // RAM model: acknowledges after ram_delay cycles, checks the request is held
  initial begin
    logic [31:0] a, d;
    logic [63:0] e;
    logic abort;
    forever begin
      @(negedge clk);
      if (RAMSchreiben) begin
        write_count++;
        a = RAMAdresse;
        d = RAMDaten;
        chk("ram_erwartet", 32'(exp_ram_q.size() != 0), 32'd1);
        if (exp_ram_q.size() != 0) begin
          e = exp_ram_q.pop_front();
          chk("ram_adresse", a, e[63:32]);
          chk("ram_daten", d, e[31:0]);
        end
        abort = 1'b0;
        for (int k = 0; k < ram_delay; k++) begin
          @(negedge clk);
          if (!RAMSchreiben) begin
            chk("ram_halt_req", 32'(Reset), 32'd1);
            abort = 1'b1;
            break;
          end
          chk("ram_halt_adr", RAMAdresse, a);
          chk("ram_halt_dat", RAMDaten, d);
        end
        if (!abort) begin
          RAMGeschrieben = 1'b1;
          @(negedge clk);
          RAMGeschrieben = 1'b0;
          chk("ram_freigabe", 32'(RAMSchreiben), 32'd0);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_sb();
    exp_sd_q.delete();
    exp_ram_q.delete();
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    repeat (2) tick();
    Reset = 1'b0;
    clear_sb();
  endtask

  task automatic setup(input logic [31:0] n, input int sd_reads, input int writes);
    sd_mem[0] = n;
    for (int i = 0; i < sd_reads; i++) exp_sd_q.push_back(32'(i));
    for (int i = 0; i < writes; i++) exp_ram_q.push_back({32'(i), sd_mem[i+1]});
    lesen_count = 0;
    write_count = 0;
    last_lesen  = -1;
  endtask

  task automatic start_pulse();
    Start = 1'b1;
    start_cyc = cyc;
    tick();
    Start = 1'b0;
  endtask

  task automatic wait_done();
    int k = 0;
    while (!(Fertig || Fehler) && k < 5000) begin tick(); k++; end
    chk("timeout_fertig", 32'(k < 5000), 32'd1);
  endtask

  task automatic wait_write(input logic [31:0] adr);
    int k = 0;
    while (!(Zustand == 3'd5 && RAMAdresse == adr) && k < 5000) begin tick(); k++; end
    chk("timeout_schreiben", 32'(k < 5000), 32'd1);
  endtask

  task automatic scoreboard_leer();
    chk("sd_rest", 32'(exp_sd_q.size()), 32'd0);
    chk("ram_rest", 32'(exp_ram_q.size()), 32'd0);
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0; SDBusy = 1'b0; SDDaten = 32'd0; RAMGeschrieben = 1'b0;
    for (int i = 0; i < 8; i++) sd_mem[i] = 32'd0;
    do_reset();

    // reset state
    chk("rst_zustand", 32'(Zustand), 32'd0);
    chk("rst_cpureset", 32'(CPUReset), 32'd1);
    chk("rst_fertig", 32'(Fertig), 32'd0);
    chk("rst_fehler", 32'(Fehler), 32'd0);
    chk("rst_sdlesen", 32'(SDLesen), 32'd0);
    chk("rst_ramschreiben", 32'(RAMSchreiben), 32'd0);
    chk("rst_sdadresse", SDAdresse, 32'd0);
    chk("rst_ramadresse", RAMAdresse, 32'd0);
    chk("rst_ramdaten", RAMDaten, 32'd0);

    // normal 3-word load, immediate ack, then Start in FERTIG
    sd_mem[1] = 32'hA0; sd_mem[2] = 32'hB1; sd_mem[3] = 32'hC2;
    setup(32'd3, 4, 3);
    start_pulse();
    wait_done();
    chk("n3_fertig", 32'(Fertig), 32'd1);
    chk("n3_cpureset", 32'(CPUReset), 32'd0);
    chk("n3_fehler", 32'(Fehler), 32'd0);
    chk("n3_zustand", 32'(Zustand), 32'd6);
    chk("n3_lesen", 32'(lesen_count), 32'd4);
    chk("n3_writes", 32'(write_count), 32'd3);
    scoreboard_leer();
    start_pulse();
    repeat (20) tick();
    chk("fertig_start_zustand", 32'(Zustand), 32'd6);
    chk("fertig_start_lesen", 32'(lesen_count), 32'd4);

    // slow busy, 5-cycle ack, Start pulsed during AUF_DATEN
    do_reset();
    ram_delay = 5; busy_len = 3;
    setup(32'd3, 4, 3);
    start_pulse();
    begin
      int k = 0;
      while (Zustand != 3'd4 && k < 1000) begin tick(); k++; end
      chk("timeout_auf_daten", 32'(k < 1000), 32'd1);
    end
    Start = 1'b1;
    tick();
    Start = 1'b0;
    wait_done();
    chk("slow_fertig", 32'(Fertig), 32'd1);
    chk("slow_lesen", 32'(lesen_count), 32'd4);
    chk("slow_writes", 32'(write_count), 32'd3);
    scoreboard_leer();

    // length 0 with Start held across reset release
    ram_delay = 0; busy_len = 1;
    Reset = 1'b1; Start = 1'b1;
    repeat (2) tick();
    clear_sb();
    setup(32'd0, 1, 0);
    start_cyc = cyc;
    Reset = 1'b0;
    tick();
    chk("start_ueber_reset", 32'(Zustand), 32'd1);
    Start = 1'b0;
    wait_done();
    chk("n0_fertig", 32'(Fertig), 32'd1);
    chk("n0_fehler", 32'(Fehler), 32'd0);
    chk("n0_cpureset", 32'(CPUReset), 32'd0);
    chk("n0_writes", 32'(write_count), 32'd0);
    chk("n0_lesen", 32'(lesen_count), 32'd1);

    // length MAXWORTE+1 is an error
    do_reset();
    setup(32'd32769, 1, 0);
    start_pulse();
    wait_done();
    chk("err_fehler", 32'(Fehler), 32'd1);
    chk("err_fertig", 32'(Fertig), 32'd0);
    chk("err_cpureset", 32'(CPUReset), 32'd1);
    chk("err_zustand", 32'(Zustand), 32'd7);
    chk("err_writes", 32'(write_count), 32'd0);
    start_pulse();
    repeat (10) tick();
    chk("err_bleibt", 32'(Zustand), 32'd7);
    chk("err_lesen", 32'(lesen_count), 32'd1);

    // length exactly MAXWORTE is legal: first write appears, then abort by reset
    do_reset();
    ram_delay = 50;
    sd_mem[1] = 32'h1234;
    setup(32'd32768, 2, 1);
    start_pulse();
    wait_write(32'd0);
    chk("max_fehler", 32'(Fehler), 32'd0);
    chk("max_ramdaten", RAMDaten, 32'h1234);
    Reset = 1'b1;
    tick();
    chk("max_rst_schreiben", 32'(RAMSchreiben), 32'd0);
    chk("max_rst_zustand", 32'(Zustand), 32'd0);
    tick();
    Reset = 1'b0;
    clear_sb();

    // reset in SCHREIBEN at word 2 of 3, then a fresh load restarts at SD word 0
    sd_mem[1] = 32'hA0; sd_mem[2] = 32'hB1; sd_mem[3] = 32'hC2;
    ram_delay = 5;
    setup(32'd3, 4, 3);
    start_pulse();
    wait_write(32'd1);
    Reset = 1'b1;
    tick();
    chk("mid_rst_schreiben", 32'(RAMSchreiben), 32'd0);
    chk("mid_rst_zustand", 32'(Zustand), 32'd0);
    chk("mid_rst_cpureset", 32'(CPUReset), 32'd1);
    tick();
    Reset = 1'b0;
    clear_sb();
    ram_delay = 0;
    sd_mem[1] = 32'hD0; sd_mem[2] = 32'hE1;
    setup(32'd2, 3, 2);
    start_pulse();
    wait_done();
    chk("reload_fertig", 32'(Fertig), 32'd1);
    chk("reload_lesen", 32'(lesen_count), 32'd3);
    chk("reload_writes", 32'(write_count), 32'd2);
    scoreboard_leer();

    repeat (3) tick();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
